// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : shared VGA timing types, 640x480@60 defaults, mode check
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1024;

  localparam int unsigned H_VIEW_DEF  = 640;
  localparam int unsigned H_FRONT_DEF = 16;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BACK_DEF  = 48;
  localparam int unsigned V_VIEW_DEF  = 480;
  localparam int unsigned V_FRONT_DEF = 10;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BACK_DEF  = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  function automatic bit timing_ok(input int unsigned view, input int unsigned front,
                                   input int unsigned sync, input int unsigned back);
    return (view != 0) && (front != 0) && (sync != 0) && (back != 0) &&
           (view + front + sync + back <= MAX_TOTAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : one raster axis (position counter + porch/sync phase FSM)
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VIEW  = H_VIEW_DEF,
  parameter int unsigned FRONT = H_FRONT_DEF,
  parameter int unsigned SYNC  = H_SYNC_DEF,
  parameter int unsigned BACK  = H_BACK_DEF,
  parameter bit          POL   = 1'b0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   step,
  output coord_t pos_next,
  output phase_t phase_next,
  output logic   wrap,
  output logic   sync_next
);

  localparam int unsigned TOTAL = VIEW + FRONT + SYNC + BACK;

  localparam coord_t LAST_POS  = coord_t'(TOTAL - 1);
  localparam coord_t END_VIEW  = coord_t'(VIEW - 1);
  localparam coord_t END_FRONT = coord_t'(VIEW + FRONT - 1);
  localparam coord_t END_SYNC  = coord_t'(VIEW + FRONT + SYNC - 1);

  if (!timing_ok(VIEW, FRONT, SYNC, BACK)) begin : g_bad_timing
    $error("vga_axis_counter: every timing term must be nonzero and the total must fit in 1024");
  end

  coord_t pos_q, pos_d;
  phase_t phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pos_q   <= LAST_POS;
      phase_q <= PH_BACK;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    wrap    = 1'b0;
    if (step) begin
      if (pos_q == LAST_POS) begin
        pos_d = '0;
        wrap  = 1'b1;
      end else begin
        pos_d = pos_q + coord_t'(1);
      end
      // Each phase is left on the last position it covers.
      case (phase_q)
        PH_ACTIVE: if (pos_q == END_VIEW)  phase_d = PH_FRONT;
        PH_FRONT:  if (pos_q == END_FRONT) phase_d = PH_SYNC;
        PH_SYNC:   if (pos_q == END_SYNC)  phase_d = PH_BACK;
        PH_BACK:   if (pos_q == LAST_POS)  phase_d = PH_ACTIVE;
        default:   phase_d = PH_BACK;
      endcase
    end
  end

  assign pos_next   = pos_d;
  assign phase_next = phase_d;
  assign sync_next  = (phase_d == PH_SYNC) ? POL : ~POL;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen : VGA raster timing generator (sync, coordinates, strobes)
// Revision: 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIEW     = H_VIEW_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VIEW     = V_VIEW_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       px_en,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  coord_t h_pos_next, v_pos_next;
  phase_t h_phase_next, v_phase_next;
  logic   h_wrap, v_wrap;
  logic   h_sync_next, v_sync_next;

  vga_axis_counter #(
    .VIEW (H_VIEW),
    .FRONT(H_FRONT),
    .SYNC (H_SYNC),
    .BACK (H_BACK),
    .POL  (H_SYNC_POL)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (px_en),
    .pos_next  (h_pos_next),
    .phase_next(h_phase_next),
    .wrap      (h_wrap),
    .sync_next (h_sync_next)
  );

  // The vertical axis only advances on the horizontal wrap, so vsync can
  // only ever change in the cycle x returns to 0.
  vga_axis_counter #(
    .VIEW (V_VIEW),
    .FRONT(V_FRONT),
    .SYNC (V_SYNC),
    .BACK (V_BACK),
    .POL  (V_SYNC_POL)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (h_wrap),
    .pos_next  (v_pos_next),
    .phase_next(v_phase_next),
    .wrap      (v_wrap),
    .sync_next (v_sync_next)
  );

  coord_t x_q, x_d, y_q, y_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  logic   active_q, active_d;
  logic   line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    x_d           = h_pos_next;
    y_d           = v_pos_next;
    hsync_d       = h_sync_next;
    vsync_d       = v_sync_next;
    active_d      = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q           <= coord_t'(H_TOTAL - 1);
      y_q           <= coord_t'(V_TOTAL - 1);
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x_px        = x_q;
  assign y_px        = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign activevideo = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen : scoreboard bench for the default mode and a small mode
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  typedef struct {
    int    cyc;
    bit    b;
    string name;
    int    x;
    int    y;
    bit    hs;
    bit    vs;
    bit    av;
    bit    ls;
    bit    fs;
  } exp_t;

  typedef struct {
    bit b;
    int k;
    int x;
    int y;
    bit hs;
    bit vs;
    bit av;
    bit ls;
    bit fs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a_n, en_a, hs_a, vs_a, av_a, ls_a, fs_a;
  logic       rst_b_n, en_b, hs_b, vs_b, av_b, ls_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   k[2];
  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   last_fs = -1;
  int   exp_period = 608;
  int   n_period = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default 640x480 mode.
  vga_sync_gen u_dut_a (
    .clk(clk), .reset_n(rst_a_n), .px_en(en_a),
    .hsync(hs_a), .vsync(vs_a), .x_px(x_a), .y_px(y_a),
    .activevideo(av_a), .line_start(ls_a), .frame_start(fs_a)
  );

  // Small 32x19 mode with active-high hsync, short enough to scan whole frames.
  vga_sync_gen #(
    .H_VIEW(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VIEW(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_b_n), .px_en(en_b),
    .hsync(hs_b), .vsync(vs_b), .x_px(x_b), .y_px(y_b),
    .activevideo(av_b), .line_start(ls_b), .frame_start(fs_b)
  );

  function automatic void chk(input string tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", tag, cyc, act, req);
    end
  endfunction

  // Position p counts enabled steps from the reset pixel (last of the frame).
  function automatic exp_t model(input bit b, input int kk, input bit strobe);
    exp_t e;
    int   hv, hf, hsw, ht, vv, vf, vsw, vt, p;
    bit   hp, vp;
    if (b) begin
      hv = 20;  hf = 3;  hsw = 4;  ht = 32;  vv = 12;  vf = 2;  vsw = 2; vt = 19;  hp = 1'b1; vp = 1'b0;
    end else begin
      hv = 640; hf = 16; hsw = 96; ht = 800; vv = 480; vf = 10; vsw = 2; vt = 525; hp = 1'b0; vp = 1'b0;
    end
    p      = (kk + ht * vt - 1) % (ht * vt);
    e.x    = p % ht;
    e.y    = p / ht;
    e.hs   = (e.x >= hv + hf && e.x < hv + hf + hsw) ? hp : !hp;
    e.vs   = (e.y >= vv + vf && e.y < vv + vf + vsw) ? vp : !vp;
    e.av   = (e.x < hv) && (e.y < vv);
    e.ls   = strobe && (e.x == 0);
    e.fs   = strobe && (p == 0);
    e.b    = b;
    e.cyc  = 0;
    e.name = "model";
    return e;
  endfunction

  function automatic void add_vec(input bit b, input int kk, input int x, input int y,
                                  input bit hs, input bit vs, input bit av, input bit ls, input bit fs);
    vec_t v;
    v.b = b; v.k = kk; v.x = x; v.y = y;
    v.hs = hs; v.vs = vs; v.av = av; v.ls = ls; v.fs = fs;
    tbl.push_back(v);
  endfunction

  task automatic drive(input bit b, input bit rstn, input bit en);
    exp_t e;
    if (b) begin rst_b_n = rstn; en_b = en; end
    else   begin rst_a_n = rstn; en_a = en; end
    if (!rstn)   k[b] = 0;
    else if (en) k[b] = k[b] + 1;
    e     = model(b, k[b], rstn && en);
    e.cyc = cyc + 1;
    sb.push_back(e);
    if (!rstn || en) begin
      foreach (tbl[i]) begin
        if (tbl[i].b == b && tbl[i].k == k[b]) begin
          e.name = $sformatf("vec_k%0d", k[b]);
          e.x = tbl[i].x; e.y = tbl[i].y; e.hs = tbl[i].hs; e.vs = tbl[i].vs;
          e.av = tbl[i].av; e.ls = tbl[i].ls; e.fs = tbl[i].fs;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input exp_t e, input int ax, input int ay, input bit ahs, input bit avs,
                     input bit aav, input bit als, input bit afs);
    string t;
    t = $sformatf("dut%0d.%s", e.b, e.name);
    chk({t, ".x_px"}, ax, e.x);
    chk({t, ".y_px"}, ay, e.y);
    chk({t, ".hsync"}, int'(ahs), int'(e.hs));
    chk({t, ".vsync"}, int'(avs), int'(e.vs));
    chk({t, ".activevideo"}, int'(aav), int'(e.av));
    chk({t, ".line_start"}, int'(als), int'(e.ls));
    chk({t, ".frame_start"}, int'(afs), int'(e.fs));
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.b) cmp(mon_e, int'(x_b), int'(y_b), hs_b, vs_b, av_b, ls_b, fs_b);
      else         cmp(mon_e, int'(x_a), int'(y_a), hs_a, vs_a, av_a, ls_a, fs_a);
    end
    if (!rst_b_n) begin
      last_fs = -1;
    end else if (fs_b) begin
      if (last_fs >= 0) begin
        chk("frame_period", cyc - last_fs, exp_period);
        n_period++;
      end
      last_fs = cyc;
    end
  end

  initial begin
    rst_a_n = 1'b0; en_a = 1'b1;
    rst_b_n = 1'b0; en_b = 1'b1;
    k[0] = 0; k[1] = 0;

    // Default mode: hand-computed points along line 0, line 1 and the gate point.
    add_vec(0, 0,    799, 524, 1, 1, 0, 0, 0);
    add_vec(0, 1,    0,   0,   1, 1, 1, 1, 1);
    add_vec(0, 2,    1,   0,   1, 1, 1, 0, 0);
    add_vec(0, 640,  639, 0,   1, 1, 1, 0, 0);
    add_vec(0, 641,  640, 0,   1, 1, 0, 0, 0);
    add_vec(0, 656,  655, 0,   1, 1, 0, 0, 0);
    add_vec(0, 657,  656, 0,   0, 1, 0, 0, 0);
    add_vec(0, 752,  751, 0,   0, 1, 0, 0, 0);
    add_vec(0, 753,  752, 0,   1, 1, 0, 0, 0);
    add_vec(0, 800,  799, 0,   1, 1, 0, 0, 0);
    add_vec(0, 801,  0,   1,   1, 1, 1, 1, 0);
    add_vec(0, 8101, 100, 10,  1, 1, 1, 0, 0);
    add_vec(0, 8102, 101, 10,  1, 1, 1, 0, 0);
    // Small mode: hsync active high on x=23..26, vsync low on y=14..15.
    add_vec(1, 0,    31,  18,  0, 1, 0, 0, 0);
    add_vec(1, 1,    0,   0,   0, 1, 1, 1, 1);
    add_vec(1, 24,   23,  0,   1, 1, 0, 0, 0);
    add_vec(1, 28,   27,  0,   0, 1, 0, 0, 0);
    add_vec(1, 249,  24,  7,   1, 1, 0, 0, 0);
    add_vec(1, 372,  19,  11,  0, 1, 1, 0, 0);
    add_vec(1, 373,  20,  11,  0, 1, 0, 0, 0);
    add_vec(1, 448,  31,  13,  0, 1, 0, 0, 0);
    add_vec(1, 449,  0,   14,  0, 0, 0, 1, 0);
    add_vec(1, 481,  0,   15,  0, 0, 0, 1, 0);
    add_vec(1, 513,  0,   16,  0, 1, 0, 1, 0);
    add_vec(1, 608,  31,  18,  0, 1, 0, 0, 0);
    add_vec(1, 609,  0,   0,   0, 1, 1, 1, 1);

    @(posedge clk);
    #1;

    // Default mode: reset, scan to (100,10), freeze 5 clks, resume.
    for (int i = 0; i < 3; i++)    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 8101; i++) drive(0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)    drive(0, 1'b1, 1'b1);
    en_a = 1'b0;

    // Small mode, px_en held high: frame period 32*19.
    exp_period = 608;
    for (int i = 0; i < 2; i++)    drive(1, 1'b0, 1'b1);
    for (int i = 0; i < 1300; i++) drive(1, 1'b1, 1'b1);

    // Small mode, px_en alternating: frame period doubles.
    exp_period = 1216;
    for (int i = 0; i < 2; i++)    drive(1, 1'b0, 1'b1);
    for (int i = 0; i < 2600; i++) drive(1, 1'b1, (i % 2) == 0);

    // Mid-frame reset while hsync is active, then restart from (0,0).
    drive(1, 1'b0, 1'b1);
    for (int i = 0; i < 249; i++)  drive(1, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)    drive(1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)    drive(1, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("frame_period_count", n_period, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator: the source end of the pixel-position interface consumed by the on-screen renderers such as the clock display. It produces hsync, vsync, the current pixel coordinates and the active-video flag, plus frame and line strobes. It sits between the pixel clock and every renderer and drives the VGA pins' sync lines. It is parameterised for any mode whose totals fit in 10 bits; the defaults give 640x480 @ 60 Hz at a 25 MHz pixel rate.

## Interface
Parameters:
- H_VIEW, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VIEW, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active low)
- V_SYNC_POL, 0, vsync active level (0 = active low)

Ports:
- clk  in  1  pixel clock; **single clock domain**
- reset_n  in  1  **synchronous, active-low** reset
- px_en  in  1  pixel advance enable; tie high for clk = pixel clock
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- x_px  out  10  current pixel column, 0..H_TOTAL-1
- y_px  out  10  current line, 0..V_TOTAL-1
- activevideo  out  1  high when x_px < H_VIEW and y_px < V_VIEW
- line_start  out  1  one-clk pulse on the step to x_px = 0
- frame_start  out  1  one-clk pulse on the step to (0,0)

## Operation
- Derived totals: H_TOTAL = sum of the four H terms (800 by default); V_TOTAL likewise (525 by default). Elaboration fails if either total exceeds 1024 or any term is 0.
- Each axis runs a phase FSM ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE, alongside its position counter.
  - Horizontal phase boundaries: x = H_VIEW, H_VIEW+H_FRONT, H_VIEW+H_FRONT+H_SYNC, and 0 on wrap.
  - Vertical phase boundaries are the same expressions using the V terms and y.
- Step rule. On a clk edge with reset_n high and px_en high:
  - x_px increments.
  - At H_TOTAL-1, x_px wraps to 0 and y_px increments.
  - At V_TOTAL-1 with x at H_TOTAL-1, y_px also wraps to 0.
- When px_en is low, every output holds, and line_start and frame_start are 0.
- Sync outputs:
  - hsync is at its active level exactly while x_px is in [H_VIEW+H_FRONT, H_VIEW+H_FRONT+H_SYNC).
  - vsync is at its active level exactly while y_px is in [V_VIEW+V_FRONT, V_VIEW+V_FRONT+V_SYNC). It changes only in the same cycle that x_px becomes 0.
- Reset (reset_n low at a clk edge) loads the last pixel of a frame, regardless of px_en or mid-frame position:
  - x_px = H_TOTAL-1, y_px = V_TOTAL-1
  - hsync and vsync at their inactive levels
  - activevideo = 0, line_start = 0, frame_start = 0
- The first enabled step after reset therefore lands on (0,0) and asserts frame_start and line_start.
- Axis phase state registers reset to BACK.

## Timing
- All outputs are registered; none has a combinational path from any input.
- hsync, vsync, activevideo and the strobes are computed from next-state counter values. They are therefore cycle-aligned with x_px/y_px: zero skew, no pipeline offset a consumer must compensate for.
- line_start and frame_start are high for exactly one clk, in the cycle in which the new coordinates are first presented. frame_start implies line_start.
- Frame period with px_en held high: H_TOTAL*V_TOTAL clks (420000 by default). With px_en asserted every Nth clk, the period is N times that.
- Downstream renderers may add their own pipeline latency. This block guarantees only in-cycle coherence of its outputs.

## Structure
- Shared package vga_timing_pkg:
  - default 640x480 constants;
  - phase enum typedef (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK);
  - 10-bit coordinate typedef.
- Sub-module vga_axis_counter, instantiated twice:
  - parameterised by VIEW/FRONT/SYNC/BACK/POL;
  - inputs: step and reset;
  - outputs: next position, phase, wrap, and sync-active level.
- Horizontal instance: step = px_en.
- Vertical instance: step = px_en and horizontal wrap.
- The top level registers the outputs and forms activevideo and the strobes.

## Test plan
- Reset release, px_en=1, defaults:
  - while in reset: x=799, y=524, activevideo=0, hsync=vsync=1;
  - one clk after release: x=0, y=0, activevideo=1, frame_start=line_start=1 for one clk only.
- Line scan:
  - hsync low for exactly x=656..751 (96 clks);
  - activevideo low for x=640..799;
  - line_start every 800 clks.
- Frame scan:
  - vsync low for y=490..491, each edge coinciding with x=0;
  - activevideo=0 for y=480..524;
  - frame_start spacing 420000 clks.
- Enable gating:
  - px_en deasserted for 5 clks at x=100, y=10: all outputs frozen, no strobes; resume at x=101.
  - px_en alternating 1/0 throughout: frame_start spacing 840000 clks.
- Reset mid-frame at (300,200) with hsync active-high (H_SYNC_POL=1):
  - next clk shows x=799, y=524, hsync=0, activevideo=0;
  - the following enabled clk shows (0,0) with frame_start=1.
